// File: rtl/anc_stream_aligner.sv
// anc_stream_aligner: front end between the per-channel I2S receivers and the ANC core.
// After reset a CFG_LEN-bit config word is shifted in serially. Once that load finishes,
// NCH independent sample streams are captured into one-deep slots, and a bundle is formed
// when every enabled slot is full. The bundle moves into a registered output stage.
// With OVERWRITE=1 a full slot keeps accepting samples, and each lost sample increments a
// saturating overrun counter for that channel.
//
// Handshake semantics (inputs and output alike): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its data stable until that
// edge. Ready may depend on state but never on the same port's valid.
module anc_stream_aligner #(
    parameter int NCH       = 4,
    parameter int W         = 16,
    parameter int CFG_LEN   = 22,
    parameter int OVERWRITE = 0,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_in,
    output logic [CFG_LEN-1:0]   cfg_bits,
    output logic                 init_done,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH*W-1:0]     in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [NCH*W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*CNT_W-1:0] ovf_cnt
);

    localparam int                   CFG_CNT_W = $clog2(CFG_LEN + 1);
    localparam logic [CFG_CNT_W-1:0] LAST_BIT  = CFG_CNT_W'(CFG_LEN - 1);
    localparam logic [CNT_W-1:0]     OVF_MAX   = '1;
    localparam bit                   OW        = (OVERWRITE != 0);

    logic [CFG_CNT_W-1:0] cnt;
    logic [NCH-1:0]       slot_full;
    logic [NCH*W-1:0]     slot_data;
    logic [NCH-1:0]       accept;
    logic [NCH-1:0]       overrun;
    logic                 all_full;
    logic                 xfer;

    // Serial config load: shift LSB-first until CFG_LEN bits are in, then freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_bits  <= '0;
            cnt       <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            cfg_bits <= CFG_LEN'({init_in, cfg_bits} >> 1);
            cnt      <= cnt + CFG_CNT_W'(1);
            if (cnt == LAST_BIT) begin
                init_done <= 1'b1;
            end
        end
    end

    // Handshake and bundle decisions, all taken from registered slot state and the live mask.
    always_comb begin
        in_ready = {NCH{init_done}} & ch_en & ({NCH{OW}} | ~slot_full);
        accept   = in_valid & in_ready;
        // A disabled channel never holds up a bundle. An all-zero mask never forms one.
        all_full = (&(slot_full | ~ch_en)) & (|ch_en);
        xfer     = all_full & (~out_valid | out_ready);
        // Replacing an untransferred sample loses data. Refilling on the xfer edge does not.
        overrun  = OW ? (accept & slot_full & ~{NCH{xfer}}) : '0;
    end

    // Capture slots: an accept wins over the xfer clear, so a same-edge refill stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            slot_data <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accept[i]) begin
                    slot_full[i]          <= 1'b1;
                    slot_data[i*W +: W]   <= in_data[i*W +: W];
                end else if (xfer && ch_en[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // Output stage: load on xfer, drop when consumed. Data holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= slot_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Per-channel overrun counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (overrun[i] && (ovf_cnt[i*CNT_W +: CNT_W] != OVF_MAX)) begin
                    ovf_cnt[i*CNT_W +: CNT_W] <= ovf_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_anc_stream_aligner.sv
// Testbench for anc_stream_aligner. It runs a backpressure instance (OVERWRITE=0) and an
// overwrite instance (OVERWRITE=1) side by side. Expected bundles come from per-channel
// sample queues: a bundle is due whenever every enabled channel has a sample waiting.
module tb_anc_stream_aligner;

    localparam int NCH     = 4;
    localparam int W       = 16;
    localparam int CFG_LEN = 22;
    localparam int CNT_W   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 init_in;
    logic [CFG_LEN-1:0]   cfg_bits, ow_cfg_bits;
    logic                 init_done, ow_init_done;
    logic [NCH-1:0]       ch_en, in_valid, in_ready;
    logic [NCH*W-1:0]     in_data, out_data;
    logic                 out_valid, out_ready;
    logic [NCH*CNT_W-1:0] ovf_cnt;
    logic [NCH-1:0]       ow_ch_en, ow_in_valid, ow_in_ready;
    logic [NCH*W-1:0]     ow_in_data, ow_out_data;
    logic                 ow_out_valid, ow_out_ready;
    logic [NCH*CNT_W-1:0] ow_ovf_cnt;

    anc_stream_aligner #(.NCH(NCH), .W(W), .CFG_LEN(CFG_LEN), .OVERWRITE(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .init_in(init_in), .cfg_bits(cfg_bits), .init_done(init_done),
        .ch_en(ch_en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ovf_cnt(ovf_cnt)
    );

    anc_stream_aligner #(.NCH(NCH), .W(W), .CFG_LEN(CFG_LEN), .OVERWRITE(1), .CNT_W(CNT_W)) dut_ow (
        .clk(clk), .rst(rst), .init_in(init_in), .cfg_bits(ow_cfg_bits), .init_done(ow_init_done),
        .ch_en(ow_ch_en), .in_data(ow_in_data), .in_valid(ow_in_valid), .in_ready(ow_in_ready),
        .out_data(ow_out_data), .out_valid(ow_out_valid), .out_ready(ow_out_ready), .ovf_cnt(ow_ovf_cnt)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [NCH*W-1:0] exp_q[$];
    logic [NCH*W-1:0] ow_exp_q[$];
    logic [W-1:0]     ch_q[NCH][$];
    logic [W-1:0]     last_acc[NCH];
    logic [NCH-1:0]   acc_last = '0;
    logic             stall_prev = 1'b0;
    logic [NCH*W-1:0] stall_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*W-1:0] pack4(input logic [W-1:0] a3, input logic [W-1:0] a2,
                                               input logic [W-1:0] a1, input logic [W-1:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic bit bundle_due();
        bit ok;
        ok = (ch_en != '0);
        for (int i = 0; i < NCH; i++) begin
            if (ch_en[i] && ch_q[i].size() == 0) ok = 0;
        end
        return ok;
    endfunction

    // Monitor and reference model, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ow_exp_q.delete();
            for (int i = 0; i < NCH; i++) begin
                ch_q[i].delete();
                last_acc[i] = '0;
            end
            acc_last   = '0;
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_bundle", out_data, '0);
                else check("bundle", out_data, exp_q.pop_front());
            end
            if (ow_out_valid && ow_out_ready) begin
                if (ow_exp_q.size() == 0) check("ow_unexpected_bundle", ow_out_data, '0);
                else check("ow_bundle", ow_out_data, ow_exp_q.pop_front());
            end
            if (stall_prev) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, stall_data);
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            // Samples handed over on the coming edge
            acc_last = in_valid & in_ready;
            for (int i = 0; i < NCH; i++) begin
                if (acc_last[i]) begin
                    ch_q[i].push_back(in_data[i*W +: W]);
                    last_acc[i] = in_data[i*W +: W];
                end
            end
            while (bundle_due()) begin
                logic [NCH*W-1:0] b;
                b = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (ch_en[i]) b[i*W +: W] = ch_q[i].pop_front();
                    else b[i*W +: W] = last_acc[i];
                end
                exp_q.push_back(b);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_ch(input int ch, input logic [W-1:0] d);
        int n;
        n = 0;
        in_data[ch*W +: W] = d;
        in_valid[ch] = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!acc_last[ch] && n < 200);
        if (!acc_last[ch]) begin
            n_checks++;
            n_errors++;
            $display("FAIL drive_timeout ch%0d: no accept after %0d cycles", ch, n);
        end
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        ow_out_ready = 1'b1;
        while ((exp_q.size() != 0 || ow_exp_q.size() != 0 || out_valid || ow_out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        check({"ow_drain_", name}, ow_exp_q.size(), 0);
    endtask

    task automatic load_cfg(input logic [CFG_LEN-1:0] v, input string name);
        for (int k = 0; k < CFG_LEN; k++) begin
            init_in = v[k];
            if (k == CFG_LEN - 1) check({name, "_ready_before_init"}, in_ready, '0);
            @(posedge clk); #1;
            if (k == CFG_LEN - 2) check({name, "_done_early"}, init_done, 1'b0);
        end
        check({name, "_done"}, init_done, 1'b1);
        check({name, "_cfg"}, cfg_bits, v);
        check({name, "_ow_cfg"}, ow_cfg_bits, v);
    endtask

    task automatic run_random(input logic [NCH-1:0] mask, input int n, input int rdy_pct);
        int rem[NCH];
        int budget;
        bit busy;
        ch_en = mask;
        for (int i = 0; i < NCH; i++) rem[i] = mask[i] ? n : 0;
        budget = 0;
        busy = 1;
        while (busy && budget < 4000) begin
            for (int i = 0; i < NCH; i++) begin
                if (!in_valid[i] && rem[i] > 0 && $urandom_range(0, 99) < 70) begin
                    in_valid[i] = 1'b1;
                    in_data[i*W +: W] = W'($urandom);
                    rem[i]--;
                end
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            @(posedge clk); #1;
            budget++;
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i] && acc_last[i]) in_valid[i] = 1'b0;
            end
            busy = (in_valid != '0);
            for (int i = 0; i < NCH; i++) if (rem[i] > 0) busy = 1;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL random_timeout mask %h: stimulus not consumed in %0d cycles", mask, budget);
            in_valid = '0;
        end
        wait_drain("random");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0]         s0, slast;
        logic [NCH*W-1:0]     bund_a;
        logic [NCH*CNT_W-1:0] ovf_exp;
        logic [CFG_LEN-1:0]   cfg_ref;
        bit                   saw_valid;

        rst = 1'b1; init_in = 1'b0; ch_en = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        ow_ch_en = '0; ow_in_valid = '0; ow_in_data = '0; ow_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg", cfg_bits, '0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_ovf", ovf_cnt, '0);
        rst = 1'b0;
        ch_en = '1;

        // Config load with the first and last bits set
        cfg_ref = '0;
        cfg_ref[0] = 1'b1;
        cfg_ref[CFG_LEN-1] = 1'b1;
        load_cfg(cfg_ref, "cfg1");
        check("cfg1_value", cfg_bits, 22'h200001);
        check("cfg1_ready_after", in_ready, 4'hF);
        for (int k = 0; k < 10; k++) begin
            init_in = ~init_in;
            @(posedge clk); #1;
        end
        check("cfg_frozen", cfg_bits, 22'h200001);

        // Alignment of staggered samples and the capture-to-valid latency
        drive_ch(0, 16'h1111);
        @(posedge clk); #1;
        drive_ch(1, 16'h2222);
        repeat (2) @(posedge clk);
        #1;
        drive_ch(2, 16'h3333);
        drive_ch(3, 16'h8000);
        check("lat_not_early", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_valid", out_valid, 1'b1);
        check("align_data", out_data, pack4(16'h8000, 16'h3333, 16'h2222, 16'h1111));
        wait_drain("align");

        // Backpressure: bundle A sits in the output stage, bundle B waits in the slots
        out_ready = 1'b0;
        bund_a = '0;
        for (int i = 0; i < NCH; i++) begin
            bund_a[i*W +: W] = W'($urandom);
            drive_ch(i, bund_a[i*W +: W]);
        end
        for (int i = 0; i < NCH; i++) drive_ch(i, W'($urandom));
        repeat (2) @(posedge clk);
        #1;
        check("bp_ready_low", in_ready, '0);
        check("bp_hold_a", out_data, bund_a);
        check("bp_valid", out_valid, 1'b1);
        wait_drain("bp");

        // Mask 0101: only ch0/ch2 are captured; ch1/ch3 keep their last samples
        ch_en = 4'b0101;
        in_valid[1] = 1'b1; in_data[1*W +: W] = 16'hDEAD;
        in_valid[3] = 1'b1; in_data[3*W +: W] = 16'hBEEF;
        #1;
        check("mask_ready", in_ready, 4'b0101);
        drive_ch(0, 16'h0A0A);
        drive_ch(2, 16'h0C0C);
        in_valid[1] = 1'b0;
        in_valid[3] = 1'b0;
        wait_drain("mask");

        // All channels masked: nothing is accepted and no bundle appears
        ch_en = '0;
        in_valid = '1;
        saw_valid = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1;
        end
        check("mask0_no_valid", saw_valid, 1'b0);
        check("mask0_ready", in_ready, '0);
        in_valid = '0;

        // Disabled slot keeps its full flag and data, and counts again once re-enabled
        ch_en = '1;
        drive_ch(1, 16'hAAAA);
        ch_en = 4'b0001;
        drive_ch(0, 16'h0101);
        wait_drain("disable");
        ch_en = '1;
        #1;
        check("retained_full", in_ready, 4'b1101);
        drive_ch(0, 16'h1010);
        drive_ch(2, 16'h2020);
        drive_ch(3, 16'h3030);
        wait_drain("reenable");

        // Random traffic under several masks and ready rates
        run_random(4'hF, 30, 100);
        run_random(4'hF, 30, 40);
        run_random(4'b1011, 25, 70);
        run_random(4'b0010, 20, 50);
        ch_en = '1;
        check("bp_ovf_zero", ovf_cnt, '0);

        // Overwrite instance: continuous stream, one bundle per cycle, no overruns
        ow_ch_en = 4'b0001;
        ow_out_ready = 1'b1;
        #1;
        check("ow_ready", ow_in_ready, 4'b0001);
        ow_in_valid[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ow_in_data[W-1:0] = W'($urandom);
            ow_exp_q.push_back(pack4('0, '0, '0, ow_in_data[W-1:0]));
            @(posedge clk); #1;
        end
        ow_in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ow_throughput", ow_exp_q.size(), 0);
        check("ow_stream_ovf", ow_ovf_cnt, '0);

        // Overwrite with the output stalled: 300 overruns saturate the counter at 255
        ow_out_ready = 1'b0;
        ow_in_valid[0] = 1'b1;
        s0 = '0;
        slast = '0;
        for (int k = 0; k < 302; k++) begin
            ow_in_data[W-1:0] = W'($urandom);
            if (k == 0) s0 = ow_in_data[W-1:0];
            if (k == 301) slast = ow_in_data[W-1:0];
            @(posedge clk); #1;
        end
        ow_in_valid[0] = 1'b0;
        ow_exp_q.push_back(pack4('0, '0, '0, s0));
        ow_exp_q.push_back(pack4('0, '0, '0, slast));
        repeat (2) @(posedge clk);
        #1;
        ovf_exp = '0;
        ovf_exp[CNT_W-1:0] = '1;
        check("ow_ovf_sat", ow_ovf_cnt, ovf_exp);
        check("ow_hold", ow_out_data, pack4('0, '0, '0, s0));
        check("ow_ready_full", ow_in_ready, 4'b0001);
        wait_drain("ow");

        // Reset while a bundle is waiting at the output and slots are partly full
        out_ready = 1'b0;
        for (int i = 0; i < NCH; i++) drive_ch(i, W'($urandom));
        drive_ch(0, W'($urandom));
        drive_ch(1, W'($urandom));
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, '0);
        check("mid_rst_init_done", init_done, 1'b0);
        check("mid_rst_cfg", cfg_bits, '0);
        check("mid_rst_ready", in_ready, '0);
        check("mid_rst_ow_ovf", ow_ovf_cnt, '0);
        rst = 1'b0;
        out_ready = 1'b1;
        load_cfg(CFG_LEN'($urandom), "cfg2");
        // Slot contents were cleared, so masked channels contribute zeros
        ch_en = 4'b0001;
        drive_ch(0, 16'h5A5A);
        wait_drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
